// File: rtl/lights_nios2_qsys_0_dct_ctrl.sv
// Nios II OCI compressed-trace buffer: packs 2-bit atoms into 34-bit frames.
// Optional LIGHTS_DCT_DROP_EN: never stall the core, drop atoms while sending.
module lights_nios2_qsys_0_dct_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        flush_req,
    output logic        tw_valid,
    output logic [33:0] tw_data,
    input  logic        tw_ready,
    output logic        flush_done,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow
);

    typedef enum logic {FILL, SEND} state_e;

    state_e      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flushing_q, flushing_d;
    logic        done_q, done_d;
    logic        eflush_q, eflush_d;
    logic        accept;

`ifdef LIGHTS_DCT_DROP_EN
    logic        ovf_q, ovf_d;

    assign atom_ready = ~reset;
    assign overflow   = ovf_q;
`else
    assign atom_ready = ~reset & (state_q == FILL);
    assign overflow   = 1'b0;
`endif

    assign accept     = atom_valid & atom_ready;
    assign tw_valid   = (state_q == SEND);
    assign tw_data    = {cnt_q, buf_q};
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign flush_done = done_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        flushing_d = flushing_q;
        done_d     = 1'b0;
        eflush_d   = 1'b0;
`ifdef LIGHTS_DCT_DROP_EN
        ovf_d      = ovf_q;
`endif
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d = buf_q | (30'(atom) << {cnt_q, 1'b0});
                    cnt_d = cnt_q + 4'd1;
                end
                if (cnt_d == 4'd15 || (flush_req && cnt_d != 4'd0)) begin
                    state_d    = SEND;
                    flushing_d = flush_req;
                end else if (flush_req && !eflush_q) begin
                    // empty flush: pulse now, then one low cycle if held
                    done_d   = 1'b1;
                    eflush_d = 1'b1;
                end
            end
            SEND: begin
`ifdef LIGHTS_DCT_DROP_EN
                if (accept) ovf_d = 1'b1;
`endif
                if (tw_ready) begin
                    state_d    = FILL;
                    buf_d      = '0;
                    cnt_d      = '0;
                    done_d     = flushing_q;
                    flushing_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            buf_q      <= '0;
            cnt_q      <= '0;
            flushing_q <= 1'b0;
            done_q     <= 1'b0;
            eflush_q   <= 1'b0;
`ifdef LIGHTS_DCT_DROP_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            flushing_q <= flushing_d;
            done_q     <= done_d;
            eflush_q   <= eflush_d;
`ifdef LIGHTS_DCT_DROP_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_lights_nios2_qsys_0_dct_ctrl.sv
// Bench for the DCT buffer controller: cycle table plus frame scoreboard.
module tb_lights_nios2_qsys_0_dct_ctrl;

`ifdef LIGHTS_DCT_DROP_EN
    localparam logic DROP = 1'b1;
`else
    localparam logic DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush_req;
    logic        tw_valid;
    logic [33:0] tw_data;
    logic        tw_ready;
    logic        flush_done;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    lights_nios2_qsys_0_dct_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .atom_valid (atom_valid),
        .atom       (atom),
        .atom_ready (atom_ready),
        .flush_req  (flush_req),
        .tw_valid   (tw_valid),
        .tw_data    (tw_data),
        .tw_ready   (tw_ready),
        .flush_done (flush_done),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [1:0]  a;
        logic        fl;
        logic        tr;
        logic        push;
        logic [33:0] frame;
        logic        e_rdy;
        logic        e_vld;
        logic [3:0]  e_cnt;
        logic        e_done;
    } vec_t;

    vec_t        vec [16];
    logic [33:0] sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stalls = 0;
    logic [29:0] m_buf = '0;
    logic [3:0]  m_cnt = '0;
    logic [33:0] last_frame = '0;
    logic [33:0] dropped;

    task automatic chk(input string nm, input logic [33:0] got,
                       input logic [33:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // frames leave at the edge after a negedge where valid & ready hold
    always @(negedge clk) begin
        #2;
        if (!reset && tw_valid && tw_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame: got unexpected %h", tw_data);
            end else begin
                chk("frame", tw_data, sb.pop_front());
            end
        end
    end

    task automatic put_atom(input logic [1:0] a, input logic fl);
        int g;
        logic [33:0] exp_bc;
        atom_valid = 1'b1;
        atom       = a;
        flush_req  = fl;
        g = 0;
        while (!atom_ready && g < 50) begin
            tick();
            g++;
        end
        if (g == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL put_atom: got no atom_ready expected ready");
        end
        stalls += g;
        m_buf[2*m_cnt +: 2] = a;
        m_cnt  = m_cnt + 4'd1;
        exp_bc = {m_cnt, m_buf};
        if (m_cnt == 4'd15 || fl) begin
            sb.push_back(exp_bc);
            last_frame = exp_bc;
            m_buf = '0;
            m_cnt = '0;
        end
        tick();
        atom_valid = 1'b0;
        flush_req  = 1'b0;
        chk("buf", {dct_count, dct_buffer}, exp_bc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1, 2'b11, 0, 1, 0, 34'd0, 1, 0, 4'd1, 0};
        vec[1]  = '{1, 2'b01, 0, 1, 0, 34'd0, 1, 0, 4'd2, 0};
        vec[2]  = '{1, 2'b10, 0, 1, 0, 34'd0, 1, 0, 4'd3, 0};
        vec[3]  = '{0, 2'b00, 1, 1, 1, {4'h3, 30'h27}, 0, 1, 4'd3, 0};
        vec[4]  = '{0, 2'b00, 0, 1, 0, 34'd0, 1, 0, 4'd0, 1};
        vec[5]  = '{0, 2'b00, 1, 1, 0, 34'd0, 1, 0, 4'd0, 1};
        vec[6]  = '{0, 2'b00, 1, 1, 0, 34'd0, 1, 0, 4'd0, 0};
        vec[7]  = '{0, 2'b00, 1, 1, 0, 34'd0, 1, 0, 4'd0, 1};
        vec[8]  = '{0, 2'b00, 0, 1, 0, 34'd0, 1, 0, 4'd0, 0};
        vec[9]  = '{1, 2'b00, 0, 1, 0, 34'd0, 1, 0, 4'd1, 0};
        vec[10] = '{1, 2'b01, 0, 1, 0, 34'd0, 1, 0, 4'd2, 0};
        vec[11] = '{1, 2'b10, 0, 1, 0, 34'd0, 1, 0, 4'd3, 0};
        vec[12] = '{1, 2'b11, 0, 1, 0, 34'd0, 1, 0, 4'd4, 0};
        vec[13] = '{1, 2'b10, 1, 0, 1, {4'h5, 30'h2E4}, 0, 1, 4'd5, 0};
        vec[14] = '{0, 2'b00, 0, 1, 0, 34'd0, 1, 0, 4'd0, 1};
        vec[15] = '{0, 2'b00, 0, 1, 0, 34'd0, 1, 0, 4'd0, 0};

        reset      = 1'b1;
        atom_valid = 1'b0;
        atom       = 2'b00;
        flush_req  = 1'b0;
        tw_ready   = 1'b1;
        @(negedge clk);
        chk("rdy_in_reset", 34'(atom_ready), 34'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rdy", 34'(atom_ready), 34'd1);
        chk("rst_vld", 34'(tw_valid), 34'd0);
        chk("rst_buf", {dct_count, dct_buffer}, 34'd0);
        chk("rst_done", 34'(flush_done), 34'd0);
        chk("rst_ovf", 34'(overflow), 34'd0);

        for (int i = 0; i < 16; i++) begin
            atom_valid = vec[i].av;
            atom       = vec[i].a;
            flush_req  = vec[i].fl;
            tw_ready   = vec[i].tr;
            if (vec[i].push) sb.push_back(vec[i].frame);
            tick();
            chk($sformatf("v%0d_rdy", i), 34'(atom_ready), 34'(vec[i].e_rdy));
            chk($sformatf("v%0d_vld", i), 34'(tw_valid), 34'(vec[i].e_vld));
            chk($sformatf("v%0d_cnt", i), 34'(dct_count), 34'(vec[i].e_cnt));
            chk($sformatf("v%0d_done", i), 34'(flush_done), 34'(vec[i].e_done));
        end
        atom_valid = 1'b0;
        flush_req  = 1'b0;

        // full frame at line rate
        tw_ready = 1'b1;
        stalls = 0;
        for (int n = 0; n < 15; n++) put_atom(2'((n % 3) + 1), 1'b0);
        chk("full_data", tw_data, {4'hF, 30'h39E79E79});
        chk("full_rdy_low", 34'(atom_ready), 34'd0);
        chk("full_stalls", 34'(stalls), 34'd0);
        tick();
        chk("full_rdy_back", 34'(atom_ready), 34'd1);
        chk("full_cnt0", 34'(dct_count), 34'd0);
        chk("full_vld0", 34'(tw_valid), 34'd0);

        // full buffer with flush: one frame only
        for (int n = 0; n < 14; n++) put_atom(2'($urandom_range(3)), 1'b0);
        put_atom(2'b11, 1'b1);
        chk("ff_vld", 34'(tw_valid), 34'd1);
        chk("ff_done0", 34'(flush_done), 34'd0);
        tick();
        chk("ff_done1", 34'(flush_done), 34'd1);
        chk("ff_vld0", 34'(tw_valid), 34'd0);
        tick();
        chk("ff_no2nd", 34'(tw_valid), 34'd0);
        chk("ff_done_end", 34'(flush_done), 34'd0);

        // writer backpressure for 10 cycles
        tw_ready = 1'b0;
        for (int n = 0; n < 15; n++) put_atom(2'($urandom_range(3)), 1'b0);
        atom_valid = 1'b1;
        atom       = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_data", tw_data, last_frame);
            chk("bp_rdy", 34'(atom_ready), 34'(DROP));
        end
        atom_valid = 1'b0;
        chk("bp_ovf", 34'(overflow), 34'(DROP));
        tw_ready = 1'b1;
        tick();
        chk("bp_cnt0", 34'(dct_count), 34'd0);
        chk("bp_vld0", 34'(tw_valid), 34'd0);

        // reset during a flushing SEND
        tw_ready = 1'b0;
        for (int n = 0; n < 4; n++) put_atom(2'(n), 1'b0);
        put_atom(2'b10, 1'b1);
        tick();
        chk("rs_vld_pre", 34'(tw_valid), 34'd1);
        dropped = sb.pop_back();
        reset = 1'b1;
        #1;
        chk("rs_rdy_in_reset", 34'(atom_ready), 34'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rs_vld", 34'(tw_valid), 34'd0);
        chk("rs_cnt", 34'(dct_count), 34'd0);
        chk("rs_done", 34'(flush_done), 34'd0);
        chk("rs_ovf", 34'(overflow), 34'd0);
        tick();
        chk("rs_done2", 34'(flush_done), 34'd0);
        tw_ready = 1'b1;
        for (int n = 0; n < 15; n++) put_atom(2'($urandom_range(3)), 1'b0);
        repeat (3) tick();
        chk("sb_empty", 34'(sb.size()), 34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
